run_count_sched: RTL and testbench
==================================

# run_count_sched

Sequencing controller for the serial run-of-ones detector (three-state Moore machine, output high one cycle after the first `1` of each run). It accepts parallel words over a valid/ready handshake, feeds them MSB-first into the detector one bit per cycle, and flushes the detector between words. It counts the detector's output pulses for each word and returns the per-word run count over a second valid/ready handshake. It sits between the word producer and the detector, which its parent instantiates.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `CNT_W`, `$clog2(WIDTH+1)`: derived width of the count; not overridden.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inValid`  in  1  producer has a word on `inData`.
- `inReady`  out  1  block accepts a word this cycle.
- `inData`  in  WIDTH  word to serialise; bit WIDTH-1 is sent first.
- `outValid`  out  1  `outCount` holds a finished result.
- `outReady`  in  1  consumer takes the result.
- `outCount`  out  CNT_W  number of detector pulses seen for the word.
- `detIn`  out  1  serial bit to the detector's `in`.
- `detOut`  in  1  detector's `out`.

## Operation
- States:
  - IDLE: `inReady`=1, `detIn`=0. On `inValid`, load the shift register and clear `bitIdx` and `count`, then go to SHIFT.
  - SHIFT: `detIn`=shift register MSB. Each cycle, shift left by 1, increment `bitIdx`, and add `detOut` to `count` when `bitIdx`≠0. When `bitIdx`=WIDTH-1, go to DRAIN.
  - DRAIN: `detIn`=0. Add `detOut` to `count`, which captures the response to the last bit. Go to DONE. Driving 0 here returns the detector to its idle state (S0) at the end of this cycle.
  - DONE: `outValid`=1, `detIn`=0. On `outReady`, go to IDLE.
- `inReady`, `outValid` and `detIn` are decoded from registered state. `detIn` is the shift register MSB, so no combinational path runs from `inValid`, `outReady` or `detOut` to any output.
- `count` is CNT_W bits and saturates at its maximum. The maximum reachable value is ceil(WIDTH/2), so saturation never triggers in legal use.
- `detIn` is never X or Z. The detector treats any non-`1` value as 0, and this block must not depend on that.
- `outCount` stays stable from `outValid` rising until the handshake completes. `inData` is sampled only at acceptance.
- Reset mid-operation: any in-flight word is discarded and no `outValid` is produced for it. The first IDLE cycle after reset drives `detIn`=0, so the detector is in S0 before the next word's first bit.
- No reset of the detector is issued by this block. The detector's own reset is the parent's responsibility.

## Timing
- Reset values: state IDLE, `inReady`=1, `outValid`=0, `outCount`=0, `detIn`=0, shift register 0.
- A word accepted at edge E0 behaves as follows:
  - Bits appear on `detIn` in cycles E0+1 .. E0+WIDTH.
  - DRAIN occupies cycle E0+WIDTH+1.
  - `outValid` rises in cycle E0+WIDTH+2, so latency is WIDTH+2 cycles.
- The detector responds one cycle after each bit: `detOut` in cycle k reflects `detIn` in cycle k-1.
- Minimum spacing between accepted words is WIDTH+3 cycles, including one DONE cycle with `outReady`=1 and one IDLE cycle.
- `inReady`=0 in SHIFT, DRAIN and DONE. There is no overlap of accept and output.
- If `outReady` is held low, DONE holds indefinitely with all outputs stable.

## Structure
- Shared package `run_count_pkg`: state enum `SchedState` {IDLE, SHIFT, DRAIN, DONE}.
- `CNT_W` is a derived localparam, not in the package.
- One natural sub-module, `word_serializer`: loadable MSB-first shift register plus `bitIdx` counter, with `last` flag output. Sequencing and counting stay in the top.
- The detector is instantiated alongside this block by the parent. The testbench instantiates both and connects `detIn`/`detOut`.

## Test plan
- Reset, then words 0x00, 0xFF, 0xAA, 0xB6, with `outReady`=1 → `outCount` = 0, 1, 4, 3 respectively; each result is asserted exactly WIDTH+2=10 cycles after acceptance.
- Back-to-back 0x01 then 0x80 → counts 1 and 1. This proves DRAIN flushes the detector, which was left in S1 after 0x01's final `1`.
- Result 0x55 (count 4) with `outReady` low for 5 cycles → `outValid` and `outCount`=4 stay stable, `inReady`=0 throughout, and `inValid` is ignored. The handshake completes in the cycle `outReady` rises, and `inReady`=1 next cycle.
- Assert `rst` asynchronously mid-SHIFT of 0xF0 → all outputs at reset values immediately. No result is produced for 0xF0. A subsequent 0x81 yields count 2.
- Hold `inValid`=1 continuously with WIDTH=4 and words 0x9, 0x6, 0xF → counts 2, 1, 1. Acceptances are exactly 7 cycles apart with `outReady` tied high.
- Throughout all tests, check with a scoreboard model that `detIn` is never X and that `detIn` is 0 in every IDLE, DRAIN and DONE cycle.

Source files
------------

// File: rtl/run_count_pkg.sv
// Shared types for the run-of-ones sequencing controller.
package run_count_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DRAIN,
      DONE
   } SchedState;

endpackage

// File: rtl/run_count_sched_if.sv
// Word-in / count-out handshake bundle between producer, controller and consumer.
interface run_count_sched_if
   import run_count_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] inData;
   logic             outValid;
   logic             outReady;
   logic [CNT_W-1:0] outCount;

   modport master (
      output inValid,
      output inData,
      output outReady,
      input  inReady,
      input  outValid,
      input  outCount
   );

   modport slave (
      input  inValid,
      input  inData,
      input  outReady,
      output inReady,
      output outValid,
      output outCount
   );

endinterface

// File: rtl/run_count_sched_word_serializer.sv
// Loadable MSB-first shift register with a bit index and a last-bit flag.
module word_serializer
   import run_count_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             msb,
   output logic             last,
   output logic [IDX_W-1:0] bitIdx
);

   logic [WIDTH-1:0] shiftReg;

   // Load wins over shift; the controller never asserts both together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shiftReg <= '0;
         bitIdx   <= '0;
      end else if (load) begin
         shiftReg <= data;
         bitIdx   <= '0;
      end else if (shift) begin
         shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
         bitIdx   <= bitIdx + IDX_W'(1);
      end
   end

   assign msb  = shiftReg[WIDTH-1];
   assign last = (bitIdx == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/run_count_sched.sv
// Feeds words bit-serially into the external run detector and reports how
// many detector pulses each word produced.
module run_count_sched
   import run_count_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   run_count_sched_if.slave bus,
   output logic             detIn,
   input  logic             detOut
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   SchedState        state;
   logic             inReadyReg;
   logic             outValidReg;
   logic [CNT_W-1:0] count;

   logic             load;
   logic             shift;
   logic             msb;
   logic             last;
   logic [IDX_W-1:0] bitIdx;

   function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] c,
                                               input logic pulse);
      if (pulse && (c != CNT_MAX))
         return c + CNT_W'(1);
      return c;
   endfunction

   assign load  = (state == IDLE) && bus.inValid;
   assign shift = (state == SHIFT);

   word_serializer #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_serializer (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .shift  (shift),
      .data   (bus.inData),
      .msb    (msb),
      .last   (last),
      .bitIdx (bitIdx)
   );

   // detOut lags detIn by one cycle, so the first SHIFT cycle still sees the
   // idle response and is skipped; DRAIN picks up the response to the last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         inReadyReg  <= 1'b1;
         outValidReg <= 1'b0;
         count       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.inValid) begin
                  state      <= SHIFT;
                  inReadyReg <= 1'b0;
                  count      <= '0;
               end
            end
            SHIFT: begin
               if (bitIdx != '0)
                  count <= satAdd(count, detOut);
               if (last)
                  state <= DRAIN;
            end
            DRAIN: begin
               count       <= satAdd(count, detOut);
               state       <= DONE;
               outValidReg <= 1'b1;
            end
            DONE: begin
               if (bus.outReady) begin
                  state       <= IDLE;
                  outValidReg <= 1'b0;
                  inReadyReg  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               inReadyReg  <= 1'b1;
               outValidReg <= 1'b0;
            end
         endcase
      end
   end

   // Outside SHIFT the detector sees 0, which parks it in its idle state.
   assign detIn        = (state == SHIFT) && msb;
   assign bus.inReady  = inReadyReg;
   assign bus.outValid = outValidReg;
   assign bus.outCount = count;

endmodule

// File: tb/tb_run_count_sched.sv
// Bench for run_count_sched: drives two instances (WIDTH 8 and 4), each wired
// to a behavioural run detector, and checks counts, timing and the serial stream.
module tb_run_count_sched;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   run_count_sched_if #(.WIDTH(8)) bus8 ();
   run_count_sched_if #(.WIDTH(4)) bus4 ();
   logic detIn8, detOut8, detIn4, detOut4;

   run_count_sched #(.WIDTH(8)) dut8 (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus8),
      .detIn  (detIn8),
      .detOut (detOut8)
   );

   run_count_sched #(.WIDTH(4)) dut4 (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus4),
      .detIn  (detIn4),
      .detOut (detOut4)
   );

   // Detector: 0 = idle, 1 = first one of a run (pulse), 2 = inside a run.
   function automatic int detNext(input int s, input logic bitIn);
      if (bitIn !== 1'b1) return 0;
      return (s == 0) ? 1 : 2;
   endfunction

   int detState8 = 0;
   int detState4 = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         detState8 <= 0;
         detState4 <= 0;
      end else begin
         detState8 <= detNext(detState8, detIn8);
         detState4 <= detNext(detState4, detIn4);
      end
   end
   assign detOut8 = (detState8 == 1);
   assign detOut4 = (detState4 == 1);

   function automatic int runsOf(input logic [31:0] w, input int width);
      int  n = 0;
      bit  prev = 1'b0;
      for (int i = width - 1; i >= 0; i--) begin
         if (w[i] && !prev) n++;
         prev = w[i];
      end
      return n;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d",
                  name, actual, expected, cyc);
      end
   endtask

   // Serial-stream scoreboard: cycle n after acceptance carries bit WIDTH-n,
   // every other cycle must carry 0.
   int         since8 = -1;
   int         since4 = -1;
   logic [7:0] word8 = '0;
   logic [3:0] word4 = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         since8 = -1;
         since4 = -1;
      end else begin
         if (bus8.inValid && bus8.inReady) begin
            since8 = 1;
            word8  = bus8.inData;
         end else if (since8 >= 1 && since8 <= 8) begin
            since8++;
         end
         if (bus4.inValid && bus4.inReady) begin
            since4 = 1;
            word4  = bus4.inData;
         end else if (since4 >= 1 && since4 <= 4) begin
            since4++;
         end
      end
   end

   always @(negedge clk) begin : streamCheck
      logic exp8, exp4;
      exp8 = (since8 >= 1 && since8 <= 8) ? word8[8 - since8] : 1'b0;
      exp4 = (since4 >= 1 && since4 <= 4) ? word4[4 - since4] : 1'b0;
      checkOutput("detIn8_known", 32'($isunknown(detIn8)), 32'd0);
      checkOutput("detIn8_stream", 32'(detIn8), 32'(exp8));
      checkOutput("detIn4_known", 32'($isunknown(detIn4)), 32'd0);
      checkOutput("detIn4_stream", 32'(detIn4), 32'(exp4));
   end

   // Entered and left on a falling edge; stalls the consumer for 'stall' cycles.
   task automatic applyStimulus(input logic [7:0] w, input int expCount,
                                input int stall, output int acceptCyc);
      int lat;
      int waitCnt;
      bus8.inValid  = 1'b1;
      bus8.inData   = w;
      bus8.outReady = 1'b0;
      waitCnt = 0;
      while (bus8.inReady !== 1'b1 && waitCnt < 40) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("accept_ready", 32'(bus8.inReady), 32'd1);
      acceptCyc = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      bus8.inValid = 1'b0;
      bus8.inData  = 8'($urandom);
      lat = 1;
      while (bus8.outValid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'd10);
      checkOutput("count", 32'(bus8.outCount), 32'(expCount));
      for (int s = 0; s < stall; s++) begin
         bus8.inValid = 1'b1;
         bus8.inData  = 8'($urandom);
         @(negedge clk);
         checkOutput("stall_valid", 32'(bus8.outValid), 32'd1);
         checkOutput("stall_count", 32'(bus8.outCount), 32'(expCount));
         checkOutput("stall_inReady", 32'(bus8.inReady), 32'd0);
      end
      bus8.outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.outReady = 1'b0;
      bus8.inValid  = 1'b0;
      checkOutput("post_inReady", 32'(bus8.inReady), 32'd1);
      checkOutput("post_outValid", 32'(bus8.outValid), 32'd0);
   endtask

   typedef struct {
      logic [7:0] word;
      int         expCount;
      int         stall;
   } vec_t;

   vec_t vecs[8];

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : main
      int   accA, accB, prevAcc, n;
      bit   sawResult;
      logic [7:0] rw;
      logic [3:0] w4[3];
      int   exp4[3];
      int   acc4[3];
      int   got4[$];
      int   idx;

      vecs[0] = '{8'h00, 0, 0};
      vecs[1] = '{8'hFF, 1, 0};
      vecs[2] = '{8'hAA, 4, 0};
      vecs[3] = '{8'hB6, 3, 0};
      vecs[4] = '{8'h01, 1, 0};
      vecs[5] = '{8'h80, 1, 0};
      vecs[6] = '{8'h55, 4, 5};
      vecs[7] = '{8'h81, 2, 0};

      rst           = 1'b1;
      bus8.inValid  = 1'b0;
      bus8.inData   = '0;
      bus8.outReady = 1'b0;
      bus4.inValid  = 1'b0;
      bus4.inData   = '0;
      bus4.outReady = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_inReady", 32'(bus8.inReady), 32'd1);
      checkOutput("reset_outValid", 32'(bus8.outValid), 32'd0);
      checkOutput("reset_outCount", 32'(bus8.outCount), 32'd0);
      checkOutput("reset_detIn", 32'(detIn8), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      prevAcc = 0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].word, vecs[i].expCount, vecs[i].stall, accA);
         if (i == 5)
            checkOutput("b2b_spacing", 32'(accA - prevAcc), 32'd11);
         prevAcc = accA;
      end

      // Asynchronous reset in the middle of shifting 0xF0.
      bus8.inValid = 1'b1;
      bus8.inData  = 8'hF0;
      @(posedge clk);
      @(negedge clk);
      bus8.inValid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_inReady", 32'(bus8.inReady), 32'd1);
      checkOutput("arst_outValid", 32'(bus8.outValid), 32'd0);
      checkOutput("arst_outCount", 32'(bus8.outCount), 32'd0);
      checkOutput("arst_detIn", 32'(detIn8), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sawResult = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus8.outValid === 1'b1) sawResult = 1'b1;
      end
      checkOutput("arst_no_result", 32'(sawResult), 32'd0);
      applyStimulus(vecs[7].word, vecs[7].expCount, vecs[7].stall, accB);

      // Randomized words against the run-counting reference.
      for (int i = 0; i < 24; i++) begin
         rw = 8'($urandom);
         n  = runsOf(32'(rw), 8);
         applyStimulus(rw, n, int'($urandom_range(0, 2)), accB);
      end

      // Narrow instance with inValid held high and outReady tied high.
      w4[0] = 4'h9; w4[1] = 4'h6; w4[2] = 4'hF;
      exp4[0] = 2;  exp4[1] = 1;  exp4[2] = 1;
      idx = 0;
      bus4.outReady = 1'b1;
      for (int c = 0; c < 100 && (idx < 3 || got4.size() < 3); c++) begin
         @(negedge clk);
         if (bus4.outValid === 1'b1) got4.push_back(int'(bus4.outCount));
         if (bus4.inReady === 1'b1 && idx < 3) begin
            bus4.inValid = 1'b1;
            bus4.inData  = w4[idx];
            acc4[idx]    = cyc + 1;
            idx++;
         end else if (bus4.inReady === 1'b1) begin
            bus4.inValid = 1'b0;
         end
      end
      bus4.inValid = 1'b0;
      checkOutput("w4_results", 32'(got4.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         checkOutput("w4_count", (i < got4.size()) ? 32'(got4[i]) : 32'hDEAD,
                     32'(exp4[i]));
      checkOutput("w4_spacing01", 32'(acc4[1] - acc4[0]), 32'd7);
      checkOutput("w4_spacing12", 32'(acc4[2] - acc4[1]), 32'd7);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
